// File: rtl/sysctl_pkg.sv
// Shared types and derived constants for the p601zero system clock/reset/IRQ sequencer.
package sysctl_pkg;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        RUN       = 2'd1,
        STEP_IDLE = 2'd2,
        STEP_ACT  = 2'd3
    } state_e;

    // Bits needed for a counter that spans 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int irq_div_period(input int osc_clock, input int irq_hz);
        return osc_clock / irq_hz;
    endfunction

    function automatic int half_period(input int clk_div_period);
        return 2 * clk_div_period;
    endfunction

    localparam int IRQ_DIV_PERIOD = irq_div_period(12000000, 50);
    localparam int HALF           = half_period(3);

endpackage

// File: rtl/sysctl_if.sv
// CPU-side bundle: generated clock, reset, timer IRQ, step status and bus strobe.
interface sysctl_if;
    logic sys_clk;
    logic sys_res;
    logic sys_irq;
    logic irq_ovr;
    logic step_mode;
    logic bus_strobe;
    logic irq_ack;

    modport master (
        output sys_clk, sys_res, sys_irq, irq_ovr, step_mode, bus_strobe,
        input  irq_ack
    );

    modport slave (
        input  sys_clk, sys_res, sys_irq, irq_ovr, step_mode, bus_strobe,
        output irq_ack
    );
endinterface

// File: rtl/sysctl_key_debounce.sv
// Front-panel button conditioner: 2-flop synchronizer, stability filter and a
// one-cycle press pulse on each accepted 1->0 level change.
module key_debounce
    import sysctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The accepted level only moves after the synchronized input has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = level_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/sysctl.sv
// Generates the CPU clock, delayed CPU reset and periodic timer IRQ from the board
// oscillator, with front-panel run/single-step control.
module sysctl
    import sysctl_pkg::*;
#(
    parameter int OSC_CLOCK       = 12000000,
    parameter int CLK_DIV_PERIOD  = 3,
    parameter int IRQ_HZ          = 50,
    parameter int RES_DELAY       = 4,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic      clk_in,
    input  logic      b_reset,
    input  logic      b_step,
    input  logic      b_mode,
    sysctl_if.master  bus
);

    localparam int            HALF_CYC = half_period(CLK_DIV_PERIOD);
    localparam int            IRQ_DIV  = irq_div_period(OSC_CLOCK, IRQ_HZ);
    localparam int            PW       = cnt_width(HALF_CYC);
    localparam int            TW       = cnt_width(IRQ_DIV);
    localparam int            RW       = cnt_width(RES_DELAY + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(HALF_CYC - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(IRQ_DIV - 1);
    localparam logic [RW-1:0] RES_DONE = RW'(RES_DELAY);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [RW-1:0] res_cnt_q, res_cnt_d;
    logic          sys_clk_q, sys_clk_d;
    logic          sys_res_q, sys_res_d;
    logic          irq_q, irq_d;
    logic          ovr_q, ovr_d;
    logic          step_mode_q, step_mode_d;
    logic          strobe_q, strobe_d;
    logic          armed_q, armed_d;
    logic          pre_tc, tmr_tc;
    logic          step_press, mode_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk_in (clk_in),
        .rst_n  (b_reset),
        .key_n  (b_step),
        .press  (step_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk_in (clk_in),
        .rst_n  (b_reset),
        .key_n  (b_mode),
        .press  (mode_press)
    );

    // Free-running prescaler and real-time IRQ timer; a tick beats a same-cycle ack.
    always_comb begin
        pre_tc      = (pre_q == PRE_LAST);
        tmr_tc      = (tmr_q == TMR_LAST);
        pre_d       = pre_tc ? '0 : pre_q + 1'b1;
        tmr_d       = tmr_tc ? '0 : tmr_q + 1'b1;
        irq_d       = irq_q;
        ovr_d       = ovr_q;
        step_mode_d = step_mode_q ^ mode_press;
        if (tmr_tc) begin
            irq_d = 1'b1;
            if (irq_q && !bus.irq_ack) begin
                ovr_d = 1'b1;
            end
        end else if (bus.irq_ack) begin
            irq_d = 1'b0;
        end
    end

    // Sequencer: every clock stop happens on a falling toggle so sys_clk is never cut high.
    always_comb begin
        state_d   = state_q;
        sys_clk_d = sys_clk_q;
        sys_res_d = sys_res_q;
        res_cnt_d = res_cnt_q;
        armed_d   = armed_q;
        case (state_q)
            RESET: begin
                if (pre_tc) begin
                    sys_clk_d = ~sys_clk_q;
                    if (!sys_clk_q) begin
                        if (res_cnt_q != RES_DONE) begin
                            res_cnt_d = res_cnt_q + 1'b1;
                        end
                    end else if (res_cnt_q == RES_DONE) begin
                        sys_res_d = 1'b0;
                        state_d   = step_mode_q ? STEP_IDLE : RUN;
                    end
                end
            end
            RUN: begin
                if (pre_tc) begin
                    sys_clk_d = ~sys_clk_q;
                    if (sys_clk_q && step_mode_q) begin
                        state_d = STEP_IDLE;
                    end
                end
            end
            STEP_IDLE: begin
                sys_clk_d = 1'b0;
                if (!step_mode_q) begin
                    armed_d = 1'b0;
                    state_d = RUN;
                end else begin
                    if (step_press) begin
                        armed_d = 1'b1;
                    end
                    if (pre_tc && (armed_q || step_press)) begin
                        sys_clk_d = 1'b1;
                        armed_d   = 1'b0;
                        state_d   = STEP_ACT;
                    end
                end
            end
            STEP_ACT: begin
                if (pre_tc) begin
                    sys_clk_d = 1'b0;
                    state_d   = step_mode_q ? STEP_IDLE : RUN;
                end
            end
            default: begin
                state_d = RESET;
            end
        endcase
        strobe_d = sys_clk_q & ~sys_clk_d;
    end

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            pre_q       <= '0;
            tmr_q       <= '0;
            res_cnt_q   <= '0;
            sys_clk_q   <= 1'b0;
            sys_res_q   <= 1'b1;
            irq_q       <= 1'b0;
            ovr_q       <= 1'b0;
            step_mode_q <= 1'b0;
            strobe_q    <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            tmr_q       <= tmr_d;
            res_cnt_q   <= res_cnt_d;
            sys_clk_q   <= sys_clk_d;
            sys_res_q   <= sys_res_d;
            irq_q       <= irq_d;
            ovr_q       <= ovr_d;
            step_mode_q <= step_mode_d;
            strobe_q    <= strobe_d;
            armed_q     <= armed_d;
        end
    end

    assign bus.sys_clk    = sys_clk_q;
    assign bus.sys_res    = sys_res_q;
    assign bus.sys_irq    = irq_q;
    assign bus.irq_ovr    = ovr_q;
    assign bus.step_mode  = step_mode_q;
    assign bus.bus_strobe = strobe_q;

endmodule

// File: tb/tb_sysctl.sv
// Scoreboard bench for sysctl: expected output transitions (channel, cycle, value)
// are queued by the stimulus and matched by a monitor as the DUT outputs change.
module tb_sysctl;

    logic clk_in  = 1'b0;
    logic b_reset = 1'b0;
    logic b_step  = 1'b1;
    logic b_mode  = 1'b1;

    sysctl_if sif();

    sysctl #(
        .OSC_CLOCK       (1000),
        .CLK_DIV_PERIOD  (3),
        .IRQ_HZ          (50),
        .RES_DELAY       (4),
        .DEBOUNCE_CYCLES (4)
    ) u_dut (
        .clk_in  (clk_in),
        .b_reset (b_reset),
        .b_step  (b_step),
        .b_mode  (b_mode),
        .bus     (sif.master)
    );

    always #5 clk_in = ~clk_in;

    // Channels: 0 sys_clk, 1 sys_res, 2 sys_irq, 3 irq_ovr, 4 step_mode, 5 bus_strobe
    wire [5:0] out_v = {sif.bus_strobe, sif.step_mode, sif.irq_ovr,
                        sif.sys_irq, sif.sys_res, sif.sys_clk};
    localparam logic [5:0] RESET_V = 6'b000010;

    typedef struct {
        int ch;
        int cyc;
        bit val;
    } ev_t;

    ev_t        sb[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    bit         mon_on     = 1'b0;
    logic [5:0] mon_mask   = '0;
    logic [5:0] prev_v     = RESET_V;

    // Clock edges counted since reset release
    always @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic string chName(input int c);
        case (c)
            0: return "sys_clk";
            1: return "sys_res";
            2: return "sys_irq";
            3: return "irq_ovr";
            4: return "step_mode";
            default: return "bus_strobe";
        endcase
    endfunction

    // Monitor: every observed transition on a watched channel pops its prediction
    initial begin
        forever begin
            @(negedge clk_in);
            for (int c = 0; c < 6; c++) begin
                if (mon_on && mon_mask[c] && (out_v[c] !== prev_v[c])) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i].ch == c) begin
                            idx = i;
                            break;
                        end
                    end
                    compared++;
                    if (idx < 0) begin
                        mismatched++;
                        $display("[TB] FAIL %s: unexpected change to %0b at cycle %0d",
                                 chName(c), out_v[c], cyc);
                    end else begin
                        if (sb[idx].cyc != cyc || sb[idx].val != out_v[c]) begin
                            mismatched++;
                            $display("[TB] FAIL %s: got %0b at cycle %0d, want %0b at cycle %0d",
                                     chName(c), out_v[c], cyc, sb[idx].val, sb[idx].cyc);
                        end
                        sb.delete(idx);
                    end
                end
            end
            prev_v = out_v;
        end
    end

    task automatic pushExpect(input int ch, input int at, input bit val);
        ev_t e;
        e.ch  = ch;
        e.cyc = at;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pushPulse(input int ch, input int at);
        pushExpect(ch, at, 1'b1);
        pushExpect(ch, at + 1, 1'b0);
    endtask

    // Reset release sequence: rises at 6/18/30/42, falls and strobes at 12/24/36/48
    task automatic pushResetSeq();
        for (int k = 0; k < 4; k++) begin
            pushExpect(0, 6 + 12 * k, 1'b1);
            pushExpect(0, 12 + 12 * k, 1'b0);
            pushPulse(5, 12 + 12 * k);
        end
        pushExpect(1, 48, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [5:0] got, input logic [5:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, want %b", name, got, exp);
        end
    endtask

    // Park just after the falling clock edge that follows edge n
    task automatic gotoCycle(input int n);
        if (cyc > n) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL goto: at cycle %0d, want cycle %0d", cyc, n);
        end
        while (cyc < n) @(negedge clk_in);
        #1;
    endtask

    // sel 0 = b_step, 1 = b_mode; value is sampled from edge n+1 on
    task automatic applyStimulus(input int sel, input bit val, input int n);
        gotoCycle(n);
        if (sel == 0) b_step = val;
        else          b_mode = val;
    endtask

    task automatic ackAt(input int n);
        gotoCycle(n);
        sif.irq_ack = 1'b1;
        gotoCycle(n + 1);
        sif.irq_ack = 1'b0;
    endtask

    task automatic closeWindow();
        mon_on = 1'b0;
        foreach (sb[i]) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: missing change to %0b at cycle %0d",
                     chName(sb[i].ch), sb[i].val, sb[i].cyc);
        end
        sb.delete();
    endtask

    task automatic applyReset(input logic [5:0] mask);
        mon_on  = 1'b0;
        b_reset = 1'b0;
        b_step  = 1'b1;
        b_mode  = 1'b1;
        #1;
        checkOutput("reset_async", out_v, RESET_V);
        repeat (3) @(negedge clk_in);
        #1;
        checkOutput("reset_hold", out_v, RESET_V);
        @(negedge clk_in);
        b_reset  = 1'b1;
        #1;
        mon_mask = mask;
        mon_on   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sif.irq_ack = 1'b0;
        repeat (2) @(negedge clk_in);

        $display("[TB] reset release sequence");
        applyReset(6'b100011);
        pushResetSeq();
        gotoCycle(50);
        closeWindow();

        $display("[TB] timer with acks");
        applyReset(6'b001100);
        pushExpect(2, 20, 1'b1);
        pushExpect(2, 25, 1'b0);
        pushExpect(2, 40, 1'b1);
        pushExpect(3, 80, 1'b1);
        pushExpect(2, 85, 1'b0);
        ackAt(24);
        ackAt(59);
        ackAt(84);
        gotoCycle(90);
        closeWindow();

        $display("[TB] overrun");
        applyReset(6'b001100);
        pushExpect(2, 20, 1'b1);
        pushExpect(3, 40, 1'b1);
        pushExpect(2, 45, 1'b0);
        pushExpect(2, 60, 1'b1);
        ackAt(44);
        gotoCycle(70);
        closeWindow();
        checkOutput("ovr_sticky", {5'b0, sif.irq_ovr}, 6'b000001);

        $display("[TB] step mode, discard and glitch rejection");
        applyReset(6'b110011);
        pushResetSeq();
        pushExpect(0, 54, 1'b1);
        pushExpect(0, 60, 1'b0);
        pushPulse(5, 60);
        pushExpect(4, 57, 1'b1);
        pushExpect(0, 90, 1'b1);  pushExpect(0, 96, 1'b0);  pushPulse(5, 96);
        pushExpect(0, 120, 1'b1); pushExpect(0, 126, 1'b0); pushPulse(5, 126);
        pushExpect(0, 150, 1'b1); pushExpect(0, 156, 1'b0); pushPulse(5, 156);
        pushExpect(0, 186, 1'b1); pushExpect(0, 192, 1'b0); pushPulse(5, 192);
        pushExpect(0, 240, 1'b1); pushExpect(0, 246, 1'b0); pushPulse(5, 246);
        pushExpect(0, 312, 1'b1);
        applyStimulus(1, 1'b0, 50);
        applyStimulus(1, 1'b1, 70);
        applyStimulus(0, 1'b0, 80);
        applyStimulus(0, 1'b1, 100);
        applyStimulus(0, 1'b0, 110);
        applyStimulus(0, 1'b1, 130);
        applyStimulus(0, 1'b0, 140);
        applyStimulus(0, 1'b1, 160);
        // Second press lands while the 186..192 step pulse is high
        applyStimulus(0, 1'b0, 174);
        applyStimulus(0, 1'b1, 178);
        applyStimulus(0, 1'b0, 182);
        applyStimulus(0, 1'b1, 190);
        applyStimulus(0, 1'b0, 210);
        applyStimulus(0, 1'b1, 213);
        applyStimulus(0, 1'b0, 230);
        applyStimulus(0, 1'b1, 280);
        applyStimulus(0, 1'b0, 300);
        gotoCycle(314);
        closeWindow();
        checkOutput("pre_reset_clk_high", {5'b0, sif.sys_clk}, 6'b000001);

        $display("[TB] reset mid-step");
        applyReset(6'b110011);
        pushResetSeq();
        gotoCycle(50);
        closeWindow();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
